// File: rtl/alu_mux_pipe_pkg.sv
// alu_mux_pipe_pkg: shared select encoding and constants for the mux-ALU pipeline.
package alu_mux_pipe_pkg;
  typedef enum logic [2:0] {
    SEL_ADD = 3'd0,
    SEL_SUB = 3'd1,
    SEL_AND = 3'd2,
    SEL_OR  = 3'd3,
    SEL_XOR = 3'd4,
    SEL_SHL = 3'd5,
    SEL_SHR = 3'd6,
    SEL_INV = 3'd7
  } alu_sel_e;
  localparam int ALU_WIDTH = 8;
  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;
endpackage

// File: rtl/alu_mux_pipe_core.sv
// alu_mux_pipe_core: combinational select-driven ALU (a, b, sel) -> (y, carry, err).
module alu_mux_core
  import alu_mux_pipe_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_sel_e         sel,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             err
);
  always_comb begin
    y = '0;
    carry = 1'b0;
    err = 1'b0;
    case (sel)
      SEL_ADD: {carry, y} = {1'b0, a} + {1'b0, b};
      SEL_SUB: {carry, y} = {1'b0, a} - {1'b0, b};
      SEL_AND: y = a & b;
      SEL_OR:  y = a | b;
      SEL_XOR: y = a ^ b;
      SEL_SHL: {carry, y} = {a, 1'b0};
      SEL_SHR: {y, carry} = {1'b0, a};
      default: err = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_mux_pipe.sv
// alu_mux_pipe: two-stage valid/ready mux-ALU pipeline.
// Define ALU_ERR_CNT_EN to add the saturating invalid-select counter port err_cnt.
module alu_mux_pipe
  import alu_mux_pipe_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_err
`ifdef ALU_ERR_CNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  alu_sel_e         s1_sel;
  logic [WIDTH-1:0] core_y;
  logic             core_carry;
  logic             core_err;
  logic             s1_adv;
  logic             s2_adv;
  assign s2_adv = !out_valid || out_ready;
  assign s1_adv = !s1_valid || s2_adv;
  assign in_ready = s1_adv && !rst;
  alu_mux_core #(.WIDTH(WIDTH)) u_core (
    .a    (s1_a),
    .b    (s1_b),
    .sel  (s1_sel),
    .y    (core_y),
    .carry(core_carry),
    .err  (core_err)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
      s1_sel <= SEL_ADD;
      out_valid <= 1'b0;
      out_y <= '0;
      out_carry <= 1'b0;
      out_zero <= 1'b0;
      out_err <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_a <= in_a;
          s1_b <= in_b;
          s1_sel <= alu_sel_e'(in_sel);
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_y <= core_y;
          out_carry <= core_carry;
          out_zero <= (core_y == '0);
          out_err <= core_err;
        end
      end
    end
  end
`ifdef ALU_ERR_CNT_EN
  // Counted at input acceptance, so dropped-by-reset transactions still count until rst clears it.
  always_ff @(posedge clk) begin
    if (rst) err_cnt <= '0;
    else if (in_valid && in_ready && alu_sel_e'(in_sel) == SEL_INV && err_cnt != ERR_CNT_MAX)
      err_cnt <= err_cnt + 8'd1;
  end
`endif
endmodule

// File: doc/alu_mux_pipe.md
Name: alu_mux_pipe

Overview:
- Two-stage pipelined, select-driven ALU with valid/ready handshakes on input and output.
- It is the design-side end of the mux-ALU interface that the layered testbench drives and monitors: the driver pushes operand/select transactions in, and the monitor samples results out.
- Covers the seven legal selects (0..6), flags the invalid select, and survives reset asserted mid-stream.

Parameters:
- WIDTH, 8, operand and result width in bits (legal values are 2 and above).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept an input this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_sel  in  3  operation select.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_y  out  WIDTH  result.
- out_carry  out  1  carry, borrow, or shifted-out bit.
- out_zero  out  1  out_y equals 0.
- out_err  out  1  transaction had an invalid select.
- err_cnt  out  8  present only with ALU_ERR_CNT_EN (see Optional Feature).

Behaviour:
- Clocking: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: out_valid=0, out_y=0, out_carry=0, out_zero=0, out_err=0, err_cnt=0; all internal valid bits cleared.
- in_ready is combinational and forced to 0 while rst=1.
- Handshakes: a transfer happens on a cycle where valid&&ready are both 1. An input is accepted only if in_valid&&in_ready.
- Pipeline:
  - S1 registers a, b and sel.
  - S2 registers the computed y, carry, zero and err.
  - Latency: accept at cycle N gives out_valid=1 at cycle N+2 when there is no stall.
- Flow control:
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv && !rst.
  - Full throughput of 1 transaction per cycle when out_ready is held at 1.
  - While out_valid && !out_ready: out_y, out_carry, out_zero and out_err hold stable, and S1 holds if it is occupied.
  - With both stages full and stalled, in_ready=0.
- Ops (results are modulo 2^WIDTH):
  - 0 ADD: y=a+b; carry = bit WIDTH of the sum.
  - 1 SUB: y=a-b; carry = borrow = (a<b).
  - 2 AND: carry=0.
  - 3 OR: carry=0.
  - 4 XOR: carry=0.
  - 5 SHL: y=a<<1; carry=a[WIDTH-1].
  - 6 SHR (logical): y=a>>1; carry=a[0].
  - 7 invalid: y=0, carry=0, err=1. The transaction still flows through the pipeline normally.
- out_zero = (y==0) for all selects, including invalid (so out_zero=1 for sel 7).
- Operand B is ignored for sel 5 and sel 6.
- Boundaries:
  - Simultaneous S2 drain and S1 advance in the same cycle: no bubble and no loss.
  - Reset mid-operation: in-flight transactions are dropped with no partial output, and out_valid=0 on the cycle after rst is sampled high.
  - in_valid asserted during reset: ignored.
- No state machine beyond the two per-stage valid bits. Transaction order is strictly preserved.

Optional Feature:
- Macro: ALU_ERR_CNT_EN.
- Defined:
  - Port err_cnt exists.
  - It is an 8-bit saturating count of invalid-select transactions, incremented when such a transaction is accepted at the input.
  - It holds at 255 once reached.
  - Cleared by rst.
- Undefined:
  - Neither the port nor the counter logic exists.
  - All other behaviour is identical.

Decomposition:
- Shared package holds:
  - typedef enum logic [2:0] alu_sel_e: SEL_ADD=0, SEL_SUB, SEL_AND, SEL_OR, SEL_XOR, SEL_SHL, SEL_SHR, SEL_INV=7.
  - Constant ALU_WIDTH=8.
  - Constant ERR_CNT_MAX=8'hFF.
- One sub-module, alu_mux_core: purely combinational, (a, b, sel) -> (y, carry, err). The top instantiates it between S1 and S2.
- The testbench predictor reuses the same enum.

Test Plan:
- Sanity (WIDTH=8, out_ready=1): a=8'hF0, b=8'h20, sel=0 -> 2 cycles later y=8'h10, carry=1, zero=0, err=0.
- All selects with a=8'h81, b=8'h0F:
  - SUB -> y=8'h72, carry=0
  - AND -> 8'h01
  - OR -> 8'h8F
  - XOR -> 8'h8E
  - SHL -> y=8'h02, carry=1
  - SHR -> y=8'h40, carry=1
  - SUB with a=8'h05, b=8'h07 -> y=8'hFE, carry=1.
- Invalid select: sel=7 -> y=0, zero=1, err=1. With ALU_ERR_CNT_EN, 300 such transactions -> err_cnt=255.
- Backpressure:
  - Send 4 back-to-back transactions with out_ready=0 for 5 cycles.
  - Expect in_ready=0 after 2 accepts, with outputs stable.
  - Release out_ready -> all 4 results arrive in order with no duplicates.
- Reset mid-stream: assert rst for 1 cycle with both stages full -> next cycle out_valid=0 and in_ready=1. A new transaction returns a result 2 cycles after acceptance; the dropped transactions never appear.
- Full throughput: 16 random transactions with out_ready=1 -> 16 consecutive out_valid cycles, every result matching the predictor.
